hd_bundle_accumulator: RTL and testbench

- Downstream of the HD encoder: consumes encoded hypervectors from the encoder output register and bundles them into one prototype hypervector by per-bit majority vote.
- Holds one signed saturating counter per dimension, updated once per accepted vector.
- On request, resolves the counters into a binary hypervector, which feeds the associative memory or training write-back.

---
 rtl/hd_bundle_accumulator.sv | 120 ++++++++++++
 tb/tb_hd_bundle_accumulator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hd_bundle_accumulator.sv
// Bundles encoded hypervectors into a prototype by per-bit majority vote using
// signed saturating counters; resolves on request and holds the result until consumed.
module hd_bundle_accumulator #(
  parameter int DIMENSION     = 512,
  parameter int COUNTER_WIDTH = 8,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   hv_valid_i,
  output logic                   hv_ready_o,
  input  logic [DIMENSION-1:0]   hv_i,
  input  logic                   finalize_i,
  input  logic [DIMENSION-1:0]   tie_break_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [DIMENSION-1:0]   result_o,
  output logic [COUNT_WIDTH-1:0] bundle_count_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    ACCUM,
    RESOLVE,
    DONE
  } state_e;

  // Symmetric saturation: the most-negative code is never produced.
  localparam logic signed [COUNTER_WIDTH-1:0] CNT_MAX = {1'b0, {(COUNTER_WIDTH-1){1'b1}}};
  localparam logic signed [COUNTER_WIDTH-1:0] CNT_MIN = -CNT_MAX;
  localparam logic signed [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  state_e                           state_q, state_d;
  logic signed [COUNTER_WIDTH-1:0]  cnt_q [DIMENSION];
  logic signed [COUNTER_WIDTH-1:0]  cnt_d [DIMENSION];
  logic [COUNT_WIDTH-1:0]           count_q, count_d;
  logic [DIMENSION-1:0]             result_q, result_d;
  logic                             result_valid_q, result_valid_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    count_d        = count_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    if (clear_i) begin
      state_d        = ACCUM;
      count_d        = '0;
      result_valid_d = 1'b0;
      for (int unsigned k = 0; k < DIMENSION; k++) begin
        cnt_d[k] = '0;
      end
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (hv_valid_i) begin
            for (int unsigned k = 0; k < DIMENSION; k++) begin
              if (hv_i[k]) begin
                if (cnt_q[k] != CNT_MAX) cnt_d[k] = cnt_q[k] + CNT_ONE;
              end else begin
                if (cnt_q[k] != CNT_MIN) cnt_d[k] = cnt_q[k] - CNT_ONE;
              end
            end
            if (count_q != '1) count_d = count_q + COUNT_WIDTH'(1);
          end
          if (finalize_i) state_d = RESOLVE;
        end
        RESOLVE: begin
          for (int unsigned k = 0; k < DIMENSION; k++) begin
            if (cnt_q[k] > 0)      result_d[k] = 1'b1;
            else if (cnt_q[k] < 0) result_d[k] = 1'b0;
            else                   result_d[k] = tie_break_i[k];
          end
          result_valid_d = 1'b1;
          state_d        = DONE;
        end
        DONE: begin
          if (result_ready_i) begin
            result_valid_d = 1'b0;
            count_d        = '0;
            state_d        = ACCUM;
            for (int unsigned k = 0; k < DIMENSION; k++) begin
              cnt_d[k] = '0;
            end
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= ACCUM;
      count_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      for (int unsigned k = 0; k < DIMENSION; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      for (int unsigned k = 0; k < DIMENSION; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign hv_ready_o     = (state_q == ACCUM);
  assign busy_o         = (state_q != ACCUM);
  assign result_valid_o = result_valid_q;
  assign result_o       = result_q;
  assign bundle_count_o = count_q;

endmodule

// File: tb/tb_hd_bundle_accumulator.sv
// Bench for hd_bundle_accumulator: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based majority model.
module tb_hd_bundle_accumulator;

  localparam int D  = 8;
  localparam int CW = 4;
  localparam int NW = 16;
  localparam int SAT = (1 << (CW - 1)) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          hv_valid = 1'b0;
  logic          hv_ready;
  logic [D-1:0]  hv = '0;
  logic          finalize = 1'b0;
  logic [D-1:0]  tie = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [D-1:0]  res;
  logic [NW-1:0] bcount;
  logic          busy;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: the current bundle is just the list of accepted vectors.
  logic [D-1:0] bundle_q[$];
  int           phase = 0;    // 0 accumulate, 1 resolving, 2 result held
  logic [D-1:0] m_res = '0;
  logic         m_valid = 1'b0;

  hd_bundle_accumulator #(
    .DIMENSION    (D),
    .COUNTER_WIDTH(CW),
    .COUNT_WIDTH  (NW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .hv_valid_i    (hv_valid),
    .hv_ready_o    (hv_ready),
    .hv_i          (hv),
    .finalize_i    (finalize),
    .tie_break_i   (tie),
    .result_valid_o(res_valid),
    .result_ready_i(res_ready),
    .result_o      (res),
    .bundle_count_o(bcount),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [D-1:0] majority(input logic [D-1:0] tb);
    logic [D-1:0] r;
    for (int b = 0; b < D; b++) begin
      int s = 0;
      foreach (bundle_q[i]) begin
        if (bundle_q[i][b]) s = (s < SAT) ? s + 1 : s;
        else                s = (s > -SAT) ? s - 1 : s;
      end
      r[b] = (s > 0) ? 1'b1 : (s < 0) ? 1'b0 : tb[b];
    end
    return r;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      phase = 0; bundle_q.delete(); m_res = '0; m_valid = 1'b0;
    end else if (clear) begin
      phase = 0; bundle_q.delete(); m_valid = 1'b0;
    end else begin
      case (phase)
        0: begin
          if (hv_valid) bundle_q.push_back(hv);
          if (finalize) phase = 1;
        end
        1: begin
          m_res = majority(tie); m_valid = 1'b1; phase = 2;
        end
        default: begin
          if (res_ready) begin
            bundle_q.delete(); m_valid = 1'b0; phase = 0;
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    int n = bundle_q.size();
    check_eq("ready",  32'(hv_ready), 32'(phase == 0));
    check_eq("busy",   32'(busy),     32'(phase != 0));
    check_eq("valid",  32'(res_valid), 32'(m_valid));
    check_eq("result", 32'(res),       32'(m_res));
    check_eq("count",  32'(bcount),    32'((n > 65535) ? 65535 : n));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input logic [D-1:0] v);
    hv_valid = 1'b1; hv = v;
    tick();
    hv_valid = 1'b0;
  endtask

  // Leaves the DUT in the result-held phase; checks the two-cycle latency.
  task automatic do_finalize(input logic [D-1:0] t);
    finalize = 1'b1; tie = t;
    tick();
    finalize = 1'b0;
    check_eq("lat_n1_valid", 32'(res_valid), 32'd0);
    tick();
    check_eq("lat_n2_valid", 32'(res_valid), 32'd1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    logic [D-1:0] held;
    tick(); tick();
    check_eq("rst_ready", 32'(hv_ready), 32'd1);
    check_eq("rst_busy",  32'(busy),     32'd0);
    check_eq("rst_count", 32'(bcount),   32'd0);
    rst_n = 1'b1;
    tick();

    // Majority
    push(8'hF0); push(8'hCC); push(8'hAA);
    do_finalize(8'h00);
    check_eq("maj_result", 32'(res),    32'h0000_00E8);
    check_eq("maj_count",  32'(bcount), 32'd3);
    accept();

    // Tie, then a fresh bundle
    push(8'hFF); push(8'h00);
    do_finalize(8'h5A);
    check_eq("tie_result", 32'(res), 32'h0000_005A);
    accept();
    push(8'hFF);
    do_finalize(8'h00);
    check_eq("new_result", 32'(res),    32'h0000_00FF);
    check_eq("new_count",  32'(bcount), 32'd1);
    accept();

    // Saturation
    for (int i = 0; i < 10; i++) push(8'hFF);
    for (int i = 0; i < 7; i++) push(8'h00);
    do_finalize(8'h0F);
    check_eq("sat_result", 32'(res),    32'h0000_000F);
    check_eq("sat_count",  32'(bcount), 32'd17);

    // Backpressure in the held phase
    held = res;
    hv_valid = 1'b1; hv = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_ready",  32'(hv_ready),  32'd0);
      check_eq("bp_valid",  32'(res_valid), 32'd1);
      check_eq("bp_result", 32'(res),       32'(held));
      check_eq("bp_count",  32'(bcount),    32'd17);
    end
    hv_valid = 1'b0;
    accept();
    check_eq("bp_release_ready", 32'(hv_ready), 32'd1);

    // Handshake and finalize in the same cycle
    push(8'h0F);
    hv_valid = 1'b1; hv = 8'h0F;
    do_finalize(8'hF0);
    hv_valid = 1'b0;
    check_eq("sim_result", 32'(res),    32'h0000_000F);
    check_eq("sim_count",  32'(bcount), 32'd2);
    accept();

    // Clear with handshake and finalize: vector dropped, no result
    push(8'hAA);
    clear = 1'b1; hv_valid = 1'b1; hv = 8'hAA; finalize = 1'b1;
    tick();
    clear = 1'b0; hv_valid = 1'b0; finalize = 1'b0;
    check_eq("clr_ready",  32'(hv_ready),  32'd1);
    check_eq("clr_count",  32'(bcount),    32'd0);
    check_eq("clr_valid",  32'(res_valid), 32'd0);
    check_eq("clr_result", 32'(res),       32'h0000_000F);
    tick();
    check_eq("clr_noresult", 32'(res_valid), 32'd0);
    do_finalize(8'h3C);
    check_eq("clr_empty_result", 32'(res), 32'h0000_003C);
    accept();

    // Reset while holding a result
    push(8'h81);
    do_finalize(8'h00);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mrst_valid",  32'(res_valid), 32'd0);
    check_eq("mrst_result", 32'(res),       32'd0);
    check_eq("mrst_count",  32'(bcount),    32'd0);
    check_eq("mrst_ready",  32'(hv_ready),  32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      hv_valid  = ($urandom_range(0, 9) < 6);
      hv        = D'($urandom);
      finalize  = ($urandom_range(0, 99) < 8);
      tie       = D'($urandom);
      res_ready = ($urandom_range(0, 9) < 4);
      clear     = ($urandom_range(0, 99) < 2);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1; clear = 1'b0; hv_valid = 1'b0; finalize = 1'b0; res_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
